auto_phase_sequencer: RTL and testbench

AUTO_PHASE_SEQUENCER -- requirements
Module: auto_phase_sequencer

---
 rtl/auto_phase_sequencer_pkg.sv | 18 +
 rtl/bcd2_down_counter.sv | 39 +++
 rtl/auto_phase_sequencer.sv | 137 +++++++++++++
 tb/tb_auto_phase_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/auto_phase_sequencer_pkg.sv
// Shared types and constants for the two-way automatic traffic phase sequencer.
// Light codes, phase encoding and BCD digit width live here.
package auto_phase_sequencer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        A_GREEN,
        A_YELLOW,
        B_GREEN,
        B_YELLOW
    } phase_t;

endpackage

// File: rtl/bcd2_down_counter.sv
// Two-digit BCD down counter with parallel load, decrement and hold.
// is_one flags the terminal count of 01.
module bcd2_down_counter
    import auto_phase_sequencer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] RST_H = 4'd0,
    parameter logic [DIGIT_W-1:0] RST_L = 4'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dec,
    input  logic [DIGIT_W-1:0] ld_h,
    input  logic [DIGIT_W-1:0] ld_l,
    output logic [DIGIT_W-1:0] cnt_h,
    output logic [DIGIT_W-1:0] cnt_l,
    output logic               is_one
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_h <= RST_H;
            cnt_l <= RST_L;
        end else if (load) begin
            cnt_h <= ld_h;
            cnt_l <= ld_l;
        end else if (dec) begin
            if (cnt_l == 4'd0) begin
                cnt_l <= 4'd9;
                cnt_h <= cnt_h - 4'd1;
            end else begin
                cnt_l <= cnt_l - 4'd1;
            end
        end
    end

    assign is_one = (cnt_h == 4'd0) && (cnt_l == 4'd1);

endmodule

// File: rtl/auto_phase_sequencer.sv
// Automatic two-direction traffic light sequencer with BCD countdowns
// and a single sensor-driven green extension per green phase.
module auto_phase_sequencer
    import auto_phase_sequencer_pkg::*;
#(
    parameter int GREEN_S  = 30,
    parameter int YELLOW_S = 5,
    parameter int EXT_S    = 10
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Enable_Auto,
    input  logic       Sec_Tick,
    input  logic       A_Traffic,
    input  logic       B_Traffic,
    output logic [1:0] A_Light,
    output logic [1:0] B_Light,
    output logic [3:0] A_Time_H,
    output logic [3:0] A_Time_L,
    output logic [3:0] B_Time_H,
    output logic [3:0] B_Time_L,
    output logic       Phase_Change
);

    if (GREEN_S < 1 || YELLOW_S < 1 || EXT_S < 1 ||
        GREEN_S + YELLOW_S > 99 || EXT_S + YELLOW_S > 99) begin : g_bad_params
        $error("auto_phase_sequencer: invalid phase lengths");
    end

    // Elaboration-time constants, split into tens/units digits
    localparam logic [7:0] G_BCD  = {4'(GREEN_S / 10), 4'(GREEN_S % 10)};
    localparam logic [7:0] GY_BCD = {4'((GREEN_S + YELLOW_S) / 10),
                                     4'((GREEN_S + YELLOW_S) % 10)};
    localparam logic [7:0] Y_BCD  = {4'(YELLOW_S / 10), 4'(YELLOW_S % 10)};
    localparam logic [7:0] E_BCD  = {4'(EXT_S / 10), 4'(EXT_S % 10)};
    localparam logic [7:0] EY_BCD = {4'((EXT_S + YELLOW_S) / 10),
                                     4'((EXT_S + YELLOW_S) % 10)};

    phase_t     state, state_nxt;
    logic       ext_flag, ext_nxt;
    logic       pc_nxt;
    logic       step, a_side, a_side_nxt, act_one, x_trf, o_trf;
    logic       load, dec, a_one, b_one;
    logic [7:0] act_ld, oth_ld, a_ld, b_ld;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= A_GREEN;
            ext_flag     <= 1'b0;
            Phase_Change <= 1'b0;
        end else begin
            state        <= state_nxt;
            ext_flag     <= ext_nxt;
            Phase_Change <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ext_nxt   = ext_flag;
        pc_nxt    = 1'b0;
        load      = 1'b0;
        act_ld    = 8'h00;
        oth_ld    = 8'h00;
        step      = Sec_Tick & Enable_Auto;
        a_side    = (state == A_GREEN) || (state == A_YELLOW);
        act_one   = a_side ? a_one : b_one;
        x_trf     = a_side ? A_Traffic : B_Traffic;
        o_trf     = a_side ? B_Traffic : A_Traffic;
        if (step && act_one) begin
            load = 1'b1;
            unique case (state)
                A_GREEN, B_GREEN: begin
                    if (x_trf && !o_trf && !ext_flag) begin
                        ext_nxt = 1'b1;
                        act_ld  = E_BCD;
                        oth_ld  = EY_BCD;
                    end else begin
                        state_nxt = (state == A_GREEN) ? A_YELLOW : B_YELLOW;
                        act_ld    = Y_BCD;
                        oth_ld    = Y_BCD;
                        pc_nxt    = 1'b1;
                        ext_nxt   = 1'b0;
                    end
                end
                A_YELLOW, B_YELLOW: begin
                    state_nxt = (state == A_YELLOW) ? B_GREEN : A_GREEN;
                    act_ld    = G_BCD;
                    oth_ld    = GY_BCD;
                    pc_nxt    = 1'b1;
                    ext_nxt   = 1'b0;
                end
            endcase
        end
        // Load values are phrased for the side that owns the next phase
        a_side_nxt = (state_nxt == A_GREEN) || (state_nxt == A_YELLOW);
        a_ld       = a_side_nxt ? act_ld : oth_ld;
        b_ld       = a_side_nxt ? oth_ld : act_ld;
        dec        = step & ~load;
    end

    always_comb begin
        A_Light = LIGHT_RED;
        B_Light = LIGHT_RED;
        unique case (state)
            A_GREEN:  A_Light = LIGHT_GREEN;
            A_YELLOW: A_Light = LIGHT_YELLOW;
            B_GREEN:  B_Light = LIGHT_GREEN;
            B_YELLOW: B_Light = LIGHT_YELLOW;
        endcase
    end

    bcd2_down_counter #(.RST_H(G_BCD[7:4]), .RST_L(G_BCD[3:0])) u_cnt_a (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .load   (load),
        .dec    (dec),
        .ld_h   (a_ld[7:4]),
        .ld_l   (a_ld[3:0]),
        .cnt_h  (A_Time_H),
        .cnt_l  (A_Time_L),
        .is_one (a_one)
    );

    bcd2_down_counter #(.RST_H(GY_BCD[7:4]), .RST_L(GY_BCD[3:0])) u_cnt_b (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .load   (load),
        .dec    (dec),
        .ld_h   (b_ld[7:4]),
        .ld_l   (b_ld[3:0]),
        .cnt_h  (B_Time_H),
        .cnt_l  (B_Time_L),
        .is_one (b_one)
    );

endmodule

// File: tb/tb_auto_phase_sequencer.sv
// Scoreboard bench for auto_phase_sequencer with default parameters.
// Directed stimulus pushes expected snapshots; a negedge monitor compares.
module tb_auto_phase_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Enable_Auto = 1'b1;
    logic       Sec_Tick = 1'b0;
    logic       A_Traffic = 1'b0;
    logic       B_Traffic = 1'b0;
    logic [1:0] A_Light, B_Light;
    logic [3:0] A_Time_H, A_Time_L, B_Time_H, B_Time_L;
    logic       Phase_Change;

    localparam logic [1:0] RD = 2'b00, YL = 2'b01, GR = 2'b10;

    typedef struct {
        string      nm;
        logic [1:0] al;
        logic [1:0] bl;
        logic [7:0] at;
        logic [7:0] bt;
        logic       pc;
        int         np;
        bit         clr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    auto_phase_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Enable_Auto  (Enable_Auto),
        .Sec_Tick     (Sec_Tick),
        .A_Traffic    (A_Traffic),
        .B_Traffic    (B_Traffic),
        .A_Light      (A_Light),
        .B_Light      (B_Light),
        .A_Time_H     (A_Time_H),
        .A_Time_L     (A_Time_L),
        .B_Time_H     (B_Time_H),
        .B_Time_L     (B_Time_L),
        .Phase_Change (Phase_Change)
    );

    always #5 Clk = ~Clk;

    // Monitor: counts Phase_Change pulses and checks queued snapshots
    always @(negedge Clk) begin
        exp_t e;
        if (Phase_Change) pulses++;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (A_Light !== e.al || B_Light !== e.bl ||
                {A_Time_H, A_Time_L} !== e.at ||
                {B_Time_H, B_Time_L} !== e.bt ||
                Phase_Change !== e.pc) begin
                errors++;
                $display("FAIL %s: got A=%b/%h B=%b/%h pc=%b, want A=%b/%h B=%b/%h pc=%b",
                         e.nm, A_Light, {A_Time_H, A_Time_L}, B_Light,
                         {B_Time_H, B_Time_L}, Phase_Change,
                         e.al, e.at, e.bl, e.bt, e.pc);
            end
            if (e.np >= 0) begin
                checks++;
                if (pulses != e.np) begin
                    errors++;
                    $display("FAIL %s_pulses: got %0d, want %0d", e.nm, pulses, e.np);
                end
            end
            if (e.clr) pulses = 0;
        end
    end

    task automatic expect_st(input string nm, input logic [1:0] al, bl,
                             input logic [7:0] at, bt, input logic pc,
                             input int np, input bit clr);
        exp_t e;
        e.nm = nm; e.al = al; e.bl = bl; e.at = at; e.bt = bt;
        e.pc = pc; e.np = np; e.clr = clr;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Sec_Tick = 1'b1;
            @(posedge Clk);
            #1;
            Sec_Tick = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        expect_st("reset", GR, RD, 8'h30, 8'h35, 1'b0, 0, 1'b1);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        tick(1);  expect_st("first_tick", GR, RD, 8'h29, 8'h34, 1'b0, -1, 1'b0);
        tick(28); expect_st("a_green_01", GR, RD, 8'h01, 8'h06, 1'b0, -1, 1'b0);
        tick(1);  expect_st("a_yellow", YL, RD, 8'h05, 8'h05, 1'b1, 1, 1'b0);
        @(posedge Clk);
        #1;
        expect_st("pc_one_cycle", YL, RD, 8'h05, 8'h05, 1'b0, -1, 1'b0);
        tick(5);  expect_st("b_green", RD, GR, 8'h35, 8'h30, 1'b1, 2, 1'b0);
        tick(10); B_Traffic = 1'b1;
        tick(10); B_Traffic = 1'b0;
        expect_st("b_mid_sensor", RD, GR, 8'h15, 8'h10, 1'b0, -1, 1'b0);
        tick(9);  expect_st("b_green_01", RD, GR, 8'h06, 8'h01, 1'b0, -1, 1'b0);
        tick(1);  expect_st("b_yellow", RD, YL, 8'h05, 8'h05, 1'b1, 3, 1'b0);
        tick(5);  expect_st("full_cycle", GR, RD, 8'h30, 8'h35, 1'b1, 4, 1'b1);

        tick(29); A_Traffic = 1'b1;
        tick(1);  expect_st("a_extend", GR, RD, 8'h10, 8'h15, 1'b0, 0, 1'b0);
        tick(9);  expect_st("a_ext_01", GR, RD, 8'h01, 8'h06, 1'b0, -1, 1'b0);
        tick(1);  expect_st("a_ext_once", YL, RD, 8'h05, 8'h05, 1'b1, 1, 1'b1);

        tick(5);  expect_st("b_green2", RD, GR, 8'h35, 8'h30, 1'b1, -1, 1'b0);
        tick(30); expect_st("b_no_ext", RD, YL, 8'h05, 8'h05, 1'b1, -1, 1'b0);
        tick(5);  B_Traffic = 1'b1;
        tick(30); expect_st("both_traffic", YL, RD, 8'h05, 8'h05, 1'b1, -1, 1'b0);

        A_Traffic = 1'b0;
        tick(34); expect_st("b_green_01b", RD, GR, 8'h06, 8'h01, 1'b0, -1, 1'b0);
        tick(1);  expect_st("b_extend", RD, GR, 8'h15, 8'h10, 1'b0, -1, 1'b0);
        tick(10); expect_st("b_ext_yellow", RD, YL, 8'h05, 8'h05, 1'b1, -1, 1'b0);
        B_Traffic = 1'b0;

        tick(18); expect_st("a_at_17", GR, RD, 8'h17, 8'h22, 1'b0, -1, 1'b0);
        Enable_Auto = 1'b0;
        tick(20); expect_st("hold_17", GR, RD, 8'h17, 8'h22, 1'b0, -1, 1'b0);
        Enable_Auto = 1'b1;
        tick(1);  expect_st("resume_16", GR, RD, 8'h16, 8'h21, 1'b0, -1, 1'b0);

        tick(16); expect_st("a_yellow3", YL, RD, 8'h05, 8'h05, 1'b1, -1, 1'b0);
        tick(38); expect_st("b_yellow_02", RD, YL, 8'h02, 8'h02, 1'b0, -1, 1'b0);
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        expect_st("mid_reset", GR, RD, 8'h30, 8'h35, 1'b0, -1, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        tick(1);  expect_st("post_reset_tick", GR, RD, 8'h29, 8'h34, 1'b0, -1, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge Clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d snapshots left, want 0", q.size());
        end
        @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
